// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), sync polarities and
// the per-axis total computation used by the timing generator and its counters.
package vga_timing_pkg;

   localparam logic POL_ACTIVE_LOW  = 1'b0;
   localparam logic POL_ACTIVE_HIGH = 1'b1;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CLK_DIV  = 2;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync level.
// active is the decode of the position about to be loaded, so the parent can register it.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   ACTIVE = DEF_H_ACTIVE,
   parameter int   FP     = DEF_H_FP,
   parameter int   SYNC   = DEF_H_SYNC,
   parameter int   BP     = DEF_H_BP,
   parameter logic POL    = POL_ACTIVE_LOW,
   parameter int   W      = 10
) (
   input  logic         clk,
   input  logic         clear_n,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
   localparam logic [W:0]   ACTIVE_L  = (W+1)'(ACTIVE);
   localparam logic [W:0]   SYNC_LO   = (W+1)'(ACTIVE + FP);
   localparam logic [W:0]   SYNC_HI   = (W+1)'(ACTIVE + FP + SYNC);

   generate
      if ((TOTAL - 1) > ((1 << W) - 1)) begin : g_range_err
         $error("vga_axis_counter: TOTAL-1 does not fit in count width");
      end
   endgenerate

   logic [W-1:0] count_q, count_d;
   logic         sync_q, sync_d;
   logic [W:0]   count_ext;

   always_comb begin
      wrap    = (count_q == LAST);
      count_d = count_q;
      if (inc) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
      count_ext = {1'b0, count_d};
      active    = (count_ext < ACTIVE_L);
      sync_d    = ((count_ext >= SYNC_LO) && (count_ext < SYNC_HI)) ? POL : ~POL;
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count_q <= LAST;
         sync_q  <= ~POL;
      end else begin
         count_q <= count_d;
         sync_q  <= sync_d;
      end
   end

   assign count = count_q;
   assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v axis
// counters, active-video flag, line/frame strobes and a wrapping frame counter.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic HSYNC_POL = POL_ACTIVE_LOW,
   parameter logic VSYNC_POL = POL_ACTIVE_LOW,
   parameter int   CLK_DIV   = DEF_CLK_DIV,
   parameter int   CNT_W     = 10,
   parameter int   FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               clear_n,
   input  logic               enable,
   output logic               pix_en,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               hsync,
   output logic               vsync,
   output logic               bright,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   generate
      if (CLK_DIV < 1) begin : g_div_err
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
   endgenerate

   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic               pix_en_q, pix_en_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic               bright_q, bright_d;
   logic [FRAME_W-1:0] frame_count_q, frame_count_d;
   logic               tick, v_inc;
   logic               h_wrap, v_wrap, h_active, v_active;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP),
      .POL    (HSYNC_POL), .W (CNT_W)
   ) u_h_axis (
      .clk     (clk),
      .clear_n (clear_n),
      .inc     (tick),
      .count   (hcount),
      .wrap    (h_wrap),
      .active  (h_active),
      .sync    (hsync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP),
      .POL    (VSYNC_POL), .W (CNT_W)
   ) u_v_axis (
      .clk     (clk),
      .clear_n (clear_n),
      .inc     (v_inc),
      .count   (vcount),
      .wrap    (v_wrap),
      .active  (v_active),
      .sync    (vsync)
   );

   always_comb begin
      tick      = enable && (div_cnt_q == DIV_LAST);
      v_inc     = tick && h_wrap;
      div_cnt_d = '0;
      if (enable && !tick) begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
      // Strobes mark the clk in which the new position first appears.
      pix_en_d      = tick;
      line_start_d  = tick && h_wrap;
      frame_start_d = tick && h_wrap && v_wrap;
      bright_d      = h_active && v_active;
      frame_count_d = frame_count_q + FRAME_W'(frame_start_d);
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         div_cnt_q     <= '0;
         pix_en_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         bright_q      <= 1'b0;
         frame_count_q <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         pix_en_q      <= pix_en_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         bright_q      <= bright_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign pix_en      = pix_en_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign bright      = bright_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a small
// CLK_DIV=1 / active-high-sync variant, checked against hand-computed values.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clear_n, enable, clear_n_v, enable_v;
   logic       pix_en, hsync, vsync, bright, line_start, frame_start;
   logic [9:0] hcount, vcount;
   logic [7:0] frame_count;
   logic       pix_en_v, hsync_v, vsync_v, bright_v, line_start_v, frame_start_v;
   logic [3:0] hcount_v, vcount_v;
   logic [7:0] frame_count_v;

   int n_checks = 0;
   int n_fail   = 0;

   vga_timing_gen u_dut (
      .clk (clk), .clear_n (clear_n), .enable (enable),
      .pix_en (pix_en), .hcount (hcount), .vcount (vcount),
      .hsync (hsync), .vsync (vsync), .bright (bright),
      .line_start (line_start), .frame_start (frame_start),
      .frame_count (frame_count)
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .CLK_DIV (1),
      .CNT_W (4), .FRAME_W (8)
   ) u_dut_v (
      .clk (clk), .clear_n (clear_n_v), .enable (enable_v),
      .pix_en (pix_en_v), .hcount (hcount_v), .vcount (vcount_v),
      .hsync (hsync_v), .vsync (vsync_v), .bright (bright_v),
      .line_start (line_start_v), .frame_start (frame_start_v),
      .frame_count (frame_count_v)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, spacing, low_cnt, low_min, low_max, fall_h, errs, found;
      int h_m, v_m, fc_m, period;
      int pos_errs, pix_errs, hs_errs, vs_errs, br_errs, st_errs, fc_errs;
      logic prev_bright;

      clear_n = 1'b1; enable = 1'b1; clear_n_v = 1'b1; enable_v = 1'b1;
      #2;
      clear_n = 1'b0; clear_n_v = 1'b0;
      #20;
      check("rst_hcount", hcount, 799);
      check("rst_vcount", vcount, 524);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_bright", bright, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_pix_en", pix_en, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_v_hcount", hcount_v, 13);
      check("rst_v_vcount", vcount_v, 6);
      check("rst_v_hsync", hsync_v, 0);
      check("rst_v_vsync", vsync_v, 0);

      clear_n = 1'b1;
      step(1);
      check("edge1_hcount", hcount, 799);
      check("edge1_pix_en", pix_en, 0);
      step(1);
      check("edge2_hcount", hcount, 0);
      check("edge2_vcount", vcount, 0);
      check("edge2_frame_start", frame_start, 1);
      check("edge2_line_start", line_start, 1);
      check("edge2_pix_en", pix_en, 1);
      check("edge2_bright", bright, 1);
      check("edge2_frame_count", frame_count, 1);

      spacing = 0; low_cnt = 0; low_min = 9999; low_max = -1; fall_h = -1;
      prev_bright = bright;
      for (cyc = 1; cyc <= 2000; cyc++) begin
         step(1);
         if (cyc == 1) begin
            check("pix_en_one_clk", pix_en, 0);
            check("frame_start_one_clk", frame_start, 0);
         end
         if (!hsync) begin
            low_cnt++;
            if (int'(hcount) < low_min) low_min = int'(hcount);
            if (int'(hcount) > low_max) low_max = int'(hcount);
         end
         if (prev_bright && !bright) fall_h = int'(hcount);
         prev_bright = bright;
         if (line_start) begin
            spacing = cyc;
            break;
         end
      end
      check("line_start_spacing", spacing, 1600);
      check("line_wrap_hcount", hcount, 0);
      check("line_wrap_vcount", vcount, 1);
      check("hsync_low_clks", low_cnt, 192);
      check("hsync_low_first", low_min, 656);
      check("hsync_low_last", low_max, 751);
      check("bright_fall_hcount", fall_h, 640);

      found = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (pix_en && hcount == 10'd300) begin
            found = 1;
            break;
         end
      end
      check("freeze_reach_300", found, 1);
      enable = 1'b0;
      errs = 0;
      repeat (50) begin
         step(1);
         if (hcount != 10'd300 || vcount != 10'd1 || pix_en || line_start ||
             hsync != 1'b1 || vsync != 1'b1 || bright != 1'b1) errs++;
      end
      check("freeze_held_errs", errs, 0);
      enable = 1'b1;
      step(1);
      check("resume_edge1_hcount", hcount, 300);
      check("resume_edge1_pix_en", pix_en, 0);
      step(1);
      check("resume_edge2_hcount", hcount, 301);
      check("resume_edge2_pix_en", pix_en, 1);

      #3;
      clear_n = 1'b0;
      #1;
      check("aclr_hcount", hcount, 799);
      check("aclr_vcount", vcount, 524);
      check("aclr_hsync", hsync, 1);
      check("aclr_vsync", vsync, 1);
      check("aclr_bright", bright, 0);
      check("aclr_frame_count", frame_count, 0);
      check("aclr_pix_en", pix_en, 0);
      #2;
      clear_n = 1'b1;
      step(1);
      check("restart_edge1_hcount", hcount, 799);
      step(1);
      check("restart_edge2_hcount", hcount, 0);
      check("restart_edge2_frame_start", frame_start, 1);
      check("restart_edge2_frame_count", frame_count, 1);

      clear_n_v = 1'b1;
      step(1);
      check("v_first_hcount", hcount_v, 0);
      check("v_first_vcount", vcount_v, 0);
      check("v_first_frame_start", frame_start_v, 1);
      check("v_first_pix_en", pix_en_v, 1);
      check("v_first_frame_count", frame_count_v, 1);
      check("v_first_hsync", hsync_v, 0);

      h_m = 0; v_m = 0; fc_m = 1; period = 0;
      pos_errs = 0; pix_errs = 0; hs_errs = 0; vs_errs = 0;
      br_errs = 0; st_errs = 0; fc_errs = 0;
      for (int c = 1; c <= 300; c++) begin
         step(1);
         h_m++;
         if (h_m == 14) begin
            h_m = 0;
            v_m++;
            if (v_m == 7) v_m = 0;
         end
         if (h_m == 0 && v_m == 0) begin
            fc_m++;
            if (period == 0) period = c;
         end
         if (int'(hcount_v) != h_m || int'(vcount_v) != v_m) pos_errs++;
         if (!pix_en_v) pix_errs++;
         if (hsync_v != (h_m >= 10 && h_m <= 11)) hs_errs++;
         if (vsync_v != (v_m == 5)) vs_errs++;
         if (bright_v != (h_m < 8 && v_m < 4)) br_errs++;
         if (line_start_v != (h_m == 0) || frame_start_v != (h_m == 0 && v_m == 0)) st_errs++;
         if (int'(frame_count_v) != fc_m) fc_errs++;
         if (c == 98) check("v_frame_count_second", frame_count_v, 2);
      end
      check("v_frame_period", period, 98);
      check("v_position_errs", pos_errs, 0);
      check("v_pix_en_errs", pix_errs, 0);
      check("v_hsync_errs", hs_errs, 0);
      check("v_vsync_errs", vs_errs, 0);
      check("v_bright_errs", br_errs, 0);
      check("v_strobe_errs", st_errs, 0);
      check("v_frame_count_errs", fc_errs, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator; successor to the fixed 640x480 timer. Generates pixel-rate enable from the system clock, horizontal/vertical counters, sync pulses of selectable polarity, the active-video `bright` flag, line/frame start strobes and a frame counter. Sits between the system clock domain and the pixel/colour generation logic; all downstream VGA blocks key off `pix_en`, `hcount` and `vcount`.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- CLK_DIV, 2, clk cycles per pixel (>=1)
- CNT_W, 10, hcount/vcount width
- FRAME_W, 8, frame_count width

- clk  in  1  system clock
- clear_n  in  1  asynchronous, active-low reset
- enable  in  1  run; low freezes raster
- pix_en  out  1  one-clk strobe: new pixel position presented
- hcount  out  CNT_W  horizontal position, 0..H_TOTAL-1
- vcount  out  CNT_W  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- bright  out  1  inside active video
- line_start  out  1  strobe at hcount==0
- frame_start  out  1  strobe at hcount==0, vcount==0
- frame_count  out  FRAME_W  completed-frame counter, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Order per axis: active, front porch, sync, back porch.
- Divider div_cnt 0..CLK_DIV-1 counts while enable=1; internal tick when div_cnt==CLK_DIV-1. enable=0: div_cnt forced to 0, counters and all levels frozen, strobes 0.
- On tick: hcount increments; at H_TOTAL-1 wraps to 0 and vcount increments; vcount wraps at V_TOTAL-1.
- hsync = HSYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL. vsync same on vcount (changes at line boundary).
- bright = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- frame_count increments on every frame_start, wraps at 2^FRAME_W.
- Reset values: hcount=H_TOTAL-1, vcount=V_TOTAL-1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, bright=0, pix_en=0, line_start=0, frame_start=0, frame_count=0. First tick therefore lands on (0,0) with frame_start.
- clear_n low mid-frame: all outputs to reset values immediately (asynchronous), no wait for clk.
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1, or CLK_DIV<1.

## Timing
- All outputs registered; hsync/vsync/bright/strobes are decoded from next-count values so they change on the same clk edge as hcount/vcount (zero relative latency).
- pix_en, line_start, frame_start high exactly one clk, in the first clk a new position is presented. CLK_DIV=1 with enable=1: pix_en continuously high.
- After clear_n release with enable=1: first tick at the CLK_DIV-th rising edge.
- Resume after enable low: first tick CLK_DIV edges after enable returns high.
- Pixel period CLK_DIV clk; line H_TOTAL*CLK_DIV clk; frame H_TOTAL*V_TOTAL*CLK_DIV clk.

## Structure
- Package vga_timing_pkg: default 640x480@60 timing constants, H_TOTAL/V_TOTAL computation, polarity constants.
- Sub-module vga_axis_counter (params ACTIVE/FP/SYNC/BP/POL/W): inc input, count, wrap, active, sync outputs; instantiated once for horizontal (inc=tick), once for vertical (inc=tick&&h_wrap).
- Top holds divider, strobe and frame_count logic.

## Test plan
- Reset, defaults: clear_n=0 -> hcount=799, vcount=524, hsync=1, vsync=1, bright=0, frame_count=0; release with enable=1 -> 2nd edge gives (0,0), frame_start=line_start=pix_en=1, bright=1.
- Line: hsync low exactly for hcount 656..751 (192 clk); bright falls at hcount 640; 799->0 wrap increments vcount; line_start every 1600 clk.
- Frame: vsync low for vcount 490..491; frame_start spacing 840000 clk; frame_count 0->1->2.
- Freeze: enable=0 for 50 clk at hcount=300 -> counts/levels held, pix_en=0; enable=1 -> hcount=301 after 2 edges.
- Async clear at vcount=200 -> outputs at reset values before next clk edge; restart as in scenario 1.
- Variant CLK_DIV=1, HSYNC_POL=1, H 8/2/2/2, V 4/1/1/1 -> H_TOTAL=14, pix_en constant 1, hsync high for hcount 10..11, vsync high for vcount 5, frame period 98 clk.
